// File: rtl/pc_gen_pkg.sv
// Shared next-PC definitions: op class encodings and default fetch/exception vectors.
// Imported by pc_gen and pc_ras.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_COM = 3'd0,
        NPC_BR  = 3'd1,
        NPC_JAL = 3'd2,
        NPC_JR  = 3'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;
    localparam int          RAS_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty is ignored.
// Latency: top/valid are combinational views of the registered stack; updates land on the next edge.
// Backpressure: none; push, pop and clear are accepted every cycle, clear has priority.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    top_idx;

    // ptr_q is the next write slot; DEPTH is a power of two so the index wraps naturally.
    assign top_idx = ptr_q - PW'(1);
    assign valid   = (cnt_q != '0);
    assign top     = valid ? mem_q[top_idx] : '0;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push) begin
            mem_d[ptr_q] = push_dat;
            ptr_d        = ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && valid) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: exception/eret/stall/decode-redirect priority, optional RAS with JR mispredict counter.
// Latency: F_pc is registered, one cycle after inputs are sampled. Backpressure: stall holds F_pc and the RAS.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(PC_RESET_DEFAULT),
    parameter logic [WIDTH-1:0] EXC_PC    = WIDTH'(PC_EXC_DEFAULT),
    parameter int               RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic             jump,
    input  logic [WIDTH-1:0] D_pc,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] F_pc,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid,
    output logic [15:0]      mispred_cnt
);

    logic [WIDTH-1:0] f_pc_q, f_pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_off;
    logic             op_active;

    assign F_pc      = f_pc_q;
    assign seq_pc    = f_pc_q + WIDTH'(4);
    assign br_off    = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    // Decode-stage ops only act when nothing of higher priority owns this cycle.
    assign op_active = !exc_req && !eret_req && !stall;

    always_comb begin
        f_pc_d = seq_pc;
        if (exc_req) begin
            f_pc_d = EXC_PC;
        end else if (eret_req) begin
            f_pc_d = epc;
        end else if (stall) begin
            f_pc_d = f_pc_q;
        end else begin
            case (op)
                NPC_BR:  f_pc_d = jump ? (D_pc + WIDTH'(4) + br_off) : seq_pc;
                NPC_JAL: f_pc_d = {D_pc[WIDTH-1:28], imm26, 2'b00};
                NPC_JR:  f_pc_d = reg_data;
                default: f_pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_pc_q <= RESET_PC;
        end else begin
            f_pc_q <= f_pc_d;
        end
    end

`ifdef PC_GEN_RAS_EN
    logic        ras_push, ras_pop;
    logic [15:0] mispred_q, mispred_d;

    assign ras_push = op_active && (op == NPC_JAL);
    assign ras_pop  = op_active && (op == NPC_JR);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (exc_req),
        .push     (ras_push),
        .push_dat (D_pc + WIDTH'(8)),
        .pop      (ras_pop),
        .top      (ras_top),
        .valid    (ras_valid)
    );

    // The JR target always comes from reg_data; the RAS only scores how well it would have guessed.
    always_comb begin
        mispred_d = mispred_q;
        if (ras_pop && ras_valid && (ras_top != reg_data) && (mispred_q != 16'hFFFF)) begin
            mispred_d = mispred_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispred_q <= '0;
        end else begin
            mispred_q <= mispred_d;
        end
    end

    assign mispred_cnt = mispred_q;
`else
    assign ras_top     = '0;
    assign ras_valid   = 1'b0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: hand-computed PC trace, RAS contents and mispredict count.
module tb_pc_gen;
    import pc_gen_pkg::*;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  op = NPC_COM;
    logic        jump = 1'b0;
    logic [31:0] D_pc = '0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] reg_data = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] F_pc;
    logic [31:0] ras_top;
    logic        ras_valid;
    logic [15:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .op          (op),
        .jump        (jump),
        .D_pc        (D_pc),
        .imm16       (imm16),
        .imm26       (imm26),
        .reg_data    (reg_data),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .epc         (epc),
        .F_pc        (F_pc),
        .ras_top     (ras_top),
        .ras_valid   (ras_valid),
        .mispred_cnt (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RAS expectations collapse to zero when the stack is not built in.
    task automatic chk_ras(input string tag, input logic [31:0] top_e, input logic vld_e,
                           input logic [15:0] mis_e);
        chk({tag, "_top"}, ras_top, RAS_ON ? top_e : 32'h0);
        chk({tag, "_vld"}, {31'h0, ras_valid}, {31'h0, RAS_ON ? vld_e : 1'b0});
        chk({tag, "_mis"}, {16'h0, mispred_cnt}, {16'h0, RAS_ON ? mis_e : 16'h0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        // Asynchronous reset before any clock edge
        #1 reset_n = 1'b0;
        #1;
        chk("rst_pc", F_pc, 32'h0000_3000);
        chk_ras("rst", 32'h0, 1'b0, 16'd0);
        #10 reset_n = 1'b1;

        // Sequential fetch
        tick(); chk("seq1", F_pc, 32'h0000_3004);
        tick(); chk("seq2", F_pc, 32'h0000_3008);
        tick(); chk("seq3", F_pc, 32'h0000_300C);

        // Branch taken with negative offset, then not taken
        op = NPC_BR; jump = 1'b1; D_pc = 32'h0000_3010; imm16 = 16'hFFFC;
        tick(); chk("br_taken", F_pc, 32'h0000_3004);
        jump = 1'b0;
        tick(); chk("br_not", F_pc, 32'h0000_3008);

        // Undefined op encoding falls through
        op = 3'd5;
        tick(); chk("op_undef", F_pc, 32'h0000_300C);

        // JAL redirects and pushes D_pc+8
        op = NPC_JAL; D_pc = 32'h0000_3000; imm26 = 26'h0000C40;
        tick(); chk("jal", F_pc, 32'h0000_3100);
        chk_ras("jal", 32'h0000_3008, 1'b1, 16'd0);

        // Stall freezes PC and RAS, exception overrides stall and clears RAS
        stall = 1'b1; D_pc = 32'h0000_3100; imm26 = 26'h0000D00;
        tick(); chk("stall_hold", F_pc, 32'h0000_3100);
        chk_ras("stall", 32'h0000_3008, 1'b1, 16'd0);
        exc_req = 1'b1;
        tick(); chk("exc_stall", F_pc, 32'h0000_4180);
        chk_ras("exc", 32'h0, 1'b0, 16'd0);

        // eret overrides stall, JR under eret neither pops nor counts
        exc_req = 1'b0; eret_req = 1'b1; epc = 32'h0000_3200; op = NPC_JR; reg_data = 32'h0000_9999;
        tick(); chk("eret", F_pc, 32'h0000_3200);
        chk_ras("eret", 32'h0, 1'b0, 16'd0);

        // exc beats eret
        exc_req = 1'b1; op = NPC_COM;
        tick(); chk("exc_over_eret", F_pc, 32'h0000_4180);
        exc_req = 1'b0; eret_req = 1'b0; stall = 1'b0;

        // Five JALs into a depth-4 stack, oldest overwritten
        op = NPC_JAL;
        for (int i = 0; i < 5; i++) begin
            a = 32'h0000_3000 + 32'(i) * 32'h100;
            D_pc = a; imm26 = a[27:2];
            tick(); chk("jal5_pc", F_pc, a);
            chk_ras("jal5", a + 32'd8, 1'b1, 16'd0);
        end

        // Pops come back newest first; matching targets keep the counter at zero
        op = NPC_JR;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_3408 - 32'(i) * 32'h100;
            chk_ras("pop_pre", a, 1'b1, 16'd0);
            reg_data = a;
            tick(); chk("pop_pc", F_pc, a);
        end
        chk_ras("pop_empty", 32'h0, 1'b0, 16'd0);

        // JR target mismatch counts, JR on empty does not
        op = NPC_JAL; D_pc = 32'h0000_3000; imm26 = 26'h0000C00;
        tick(); chk("jal_b", F_pc, 32'h0000_3000);
        chk_ras("jal_b", 32'h0000_3008, 1'b1, 16'd0);
        op = NPC_JR; reg_data = 32'h0000_5000;
        tick(); chk("jr_mis", F_pc, 32'h0000_5000);
        chk_ras("jr_mis", 32'h0, 1'b0, 16'd1);
        reg_data = 32'h0000_6000;
        tick(); chk("jr_empty", F_pc, 32'h0000_6000);
        chk_ras("jr_empty", 32'h0, 1'b0, 16'd1);

        // Address arithmetic wraps modulo 2^32
        op = NPC_BR; jump = 1'b1; D_pc = 32'hFFFF_FFF8; imm16 = 16'h0001;
        tick(); chk("br_wrap", F_pc, 32'h0000_0000);
        op = NPC_JR; reg_data = 32'hFFFF_FFFC; jump = 1'b0;
        tick(); chk("jr_top", F_pc, 32'hFFFF_FFFC);
        op = NPC_COM;
        tick(); chk("seq_wrap", F_pc, 32'h0000_0000);

        // Reset while stalled after a redirect
        op = NPC_JAL; D_pc = 32'h0000_3000; imm26 = 26'h0001400;
        tick(); chk("jal_c", F_pc, 32'h0000_5000);
        chk_ras("jal_c", 32'h0000_3008, 1'b1, 16'd1);
        stall = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_pc", F_pc, 32'h0000_3000);
        chk_ras("rst_mid", 32'h0, 1'b0, 16'd0);
        reset_n = 1'b1; stall = 1'b0; op = NPC_COM;
        tick(); chk("rst_mid_seq", F_pc, 32'h0000_3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
